// File: rtl/wb_sram_slave_if.sv
// Wishbone classic bus bundle for wb_sram_slave; signal suffixes are from the
// slave's point of view.
interface wb_sram_slave_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_sram_slave.sv
// Wishbone classic SRAM responder with programmable wait states and byte-lane writes.
// Optional macro WB_SRAM_SLAVE_ADDR_ERR_EN: out-of-range addresses get wb_err_o instead of wb_ack_o.
module wb_sram_slave #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic            clk,
    input  logic            rst,
    wb_sram_slave_if.slave  wb
);
    localparam int          AW  = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WS4 = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     wdat_q, wdat_d;
    logic [3:0]      sel_q, sel_d;
    logic            we_q, we_d;
    logic            err_q, err_d;

    logic [31:0]     mem [DEPTH_WORDS];
    logic [31:0]     rdata_q;
    logic [AW-1:0]   rd_idx;
    logic            req;
    logic            adr_err;
    logic            resp;
    logic            unused_adr_bits;

    assign req = wb.wb_cyc_i & wb.wb_stb_i;
    assign unused_adr_bits = ^{wb.wb_adr_i[31:AW+2], wb.wb_adr_i[1:0]};

`ifdef WB_SRAM_SLAVE_ADDR_ERR_EN
    assign adr_err = (wb.wb_adr_i >> (AW + 2)) != 32'd0;
`else
    assign adr_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d   = wb.wb_adr_i[AW+1:2];
                    wdat_d  = wb.wb_dat_i;
                    sel_d   = wb.wb_sel_i;
                    we_d    = wb.wb_we_i;
                    err_d   = adr_err;
                    cnt_d   = WS4;
                    state_d = (WAIT_STATES == 0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                // Only cyc dropping aborts; stb may wander while we count down.
                if (!wb.wb_cyc_i) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        idx_q  <= idx_d;
        wdat_q <= wdat_d;
        sel_q  <= sel_d;
        we_q   <= we_d;
    end

    // Synchronous read: the word is fetched on the edge that enters ACK, so a
    // zero-wait request must index straight from the bus.
    assign rd_idx = (state_q == IDLE) ? wb.wb_adr_i[AW+1:2] : idx_q;

    always_ff @(posedge clk) begin
        rdata_q <= mem[rd_idx];
        if (!rst && state_q == ACK && we_q && !err_q) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_q[b]) begin
                    mem[idx_q][8*b +: 8] <= wdat_q[8*b +: 8];
                end
            end
        end
    end

    assign resp        = (state_q == ACK) && !rst;
    assign wb.wb_ack_o = resp && !err_q;
    assign wb.wb_dat_o = (resp && !err_q && !we_q) ? rdata_q : 32'd0;

`ifdef WB_SRAM_SLAVE_ADDR_ERR_EN
    assign wb.wb_err_o = resp && err_q;
`else
    assign wb.wb_err_o = 1'b0;
`endif

endmodule
